// File: rtl/alu_exec_mc.sv
// Multi-cycle 32-bit ALU: single-cycle logic/arith ops, iterative shift-add MUL and restoring DIV.
// Optional macro ALU_OVF_EN enables signed ADD/SUB overflow detection; otherwise overflow is tied 0.
module alu_exec_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             valid_out,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             busy
);

    localparam logic [3:0] CTL_ADD = 4'b0001;
    localparam logic [3:0] CTL_SUB = 4'b0010;
    localparam logic [3:0] CTL_MUL = 4'b0011;
    localparam logic [3:0] CTL_DIV = 4'b0100;
    localparam logic [3:0] CTL_AND = 4'b0101;
    localparam logic [3:0] CTL_OR  = 4'b0110;
    localparam logic [3:0] CTL_NOR = 4'b0111;
    localparam logic [3:0] CTL_SLT = 4'b1000;
    localparam logic [3:0] CTL_XOR = 4'b1001;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        DONE
    } aluStateT;

    aluStateT         state;
    logic [CNT_W-1:0] counter;
    logic             loadPending;
    logic             isDiv;
    logic             negQuot;
    logic             divisorZero;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] acc;

    logic             accept;
    logic [WIDTH-1:0] addRes;
    logic [WIDTH-1:0] subRes;
    logic [WIDTH-1:0] simpleRes;
    logic [WIDTH:0]   divTrial;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;
    logic [WIDTH-1:0] doneRes;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign ready_in = (state == IDLE);
    assign busy     = ~ready_in;
    assign accept   = valid_in && ready_in;

    assign addRes = op_a + op_b;
    assign subRes = op_a - op_b;

    // NOTE: every path through an always_comb must assign its outputs; the
    // default first keeps unlisted codes from inferring a latch.
    always_comb begin
        simpleRes = '0;
        case (alu_ctl)
            CTL_ADD: simpleRes = addRes;
            CTL_SUB: simpleRes = subRes;
            CTL_AND: simpleRes = op_a & op_b;
            CTL_OR:  simpleRes = op_a | op_b;
            CTL_NOR: simpleRes = ~(op_a | op_b);
            CTL_SLT: simpleRes = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
            CTL_XOR: simpleRes = op_a ^ op_b;
            default: simpleRes = '0;
        endcase
    end

    // Restoring step: remainder lives in acc, dividend shifts out of regA
    // while quotient bits shift into it from the bottom.
    assign divTrial = {acc, regA[WIDTH-1]};
    assign divFits  = (divTrial >= {1'b0, regB});
    assign divDiff  = divTrial[WIDTH-1:0] - regB;

    always_comb begin
        doneRes = acc;
        if (isDiv) begin
            if (divisorZero) begin
                doneRes = '1;
            end else begin
                doneRes = negQuot ? -regA : regA;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded at accept
    // before being read, and the FSM reset alone aborts an operation.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (accept) begin
                    regA  <= op_a;
                    regB  <= op_b;
                    acc   <= '0;
                    isDiv <= (alu_ctl == CTL_DIV);
                end
            end
            MUL: begin
                if (!loadPending) begin
                    acc  <= acc + (regB[0] ? regA : '0);
                    regA <= regA << 1;
                    regB <= regB >> 1;
                end
            end
            DIV: begin
                if (loadPending) begin
                    negQuot     <= regA[WIDTH-1] ^ regB[WIDTH-1];
                    divisorZero <= (regB == '0);
                    regA        <= absVal(regA);
                    regB        <= absVal(regB);
                end else begin
                    regA <= {regA[WIDTH-2:0], divFits};
                    acc  <= divFits ? divDiff : divTrial[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            counter     <= '0;
            loadPending <= 1'b0;
            valid_out   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment; this default
            // makes valid_out a single-cycle pulse unless a branch below sets it.
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        counter     <= '0;
                        loadPending <= 1'b1;
                        if (alu_ctl == CTL_MUL) begin
                            state <= MUL;
                        end else if (alu_ctl == CTL_DIV) begin
                            state <= DIV;
                        end else begin
                            valid_out   <= 1'b1;
                            result      <= simpleRes;
                            zero        <= (simpleRes == '0);
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                MUL, DIV: begin
                    // First cycle is the operand load; then one bit per clock.
                    if (loadPending) begin
                        loadPending <= 1'b0;
                    end else if (counter == LAST_ITER) begin
                        state <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    valid_out   <= 1'b1;
                    result      <= doneRes;
                    zero        <= (doneRes == '0);
                    div_by_zero <= isDiv && divisorZero;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_OVF_EN
    logic simpleOvf;
    logic ovfReg;

    always_comb begin
        simpleOvf = 1'b0;
        if (alu_ctl == CTL_ADD) begin
            simpleOvf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (addRes[WIDTH-1] != op_a[WIDTH-1]);
        end else if (alu_ctl == CTL_SUB) begin
            simpleOvf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (subRes[WIDTH-1] != op_a[WIDTH-1]);
        end
    end

    // Only a simple ADD/SUB completion can raise the flag; all other cycles clear it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovfReg <= 1'b0;
        end else begin
            ovfReg <= accept && simpleOvf;
        end
    end

    assign overflow = ovfReg;
`else
    assign overflow = 1'b0;
`endif

endmodule
